// File: rtl/alu_op_sequencer_if.sv
// Bundle between the ALU op sequencer and its environment: program load port,
// run control/status, and the operation/operand/result link to the accumulator ALU.
interface alu_op_sequencer_if #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic          load_valid;
    logic          load_ready;
    logic [1:0]    load_operation;
    logic [W-1:0]  load_operand;
    logic          clear;
    logic [CW-1:0] count;
    logic          start;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] mismatch_index;
    logic [1:0]    operation;
    logic [W-1:0]  operand;
    logic [W-1:0]  result;
    logic [W-1:0]  expected;

    modport master (
        output load_valid, load_operation, load_operand, clear, start, result,
        input  load_ready, count, busy, done, pass, mismatch_index,
               operation, operand, expected
    );

    modport slave (
        input  load_valid, load_operation, load_operand, clear, start, result,
        output load_ready, count, busy, done, pass, mismatch_index,
               operation, operand, expected
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues a loaded (operation, operand) program to a 4-op accumulator ALU and
// checks its registered result against a shadow accumulator, cycle by cycle.
module alu_op_sequencer #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                clock,
    input  logic                reset,
    alu_op_sequencer_if.slave   seq_io
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_e;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] operand;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        cur;
    logic          mem_we;
    logic          load_ready;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] index_q, index_d;
    logic [AW-1:0] last_q, last_d;
    logic [AW-1:0] mis_q, mis_d;
    logic [W-1:0]  expected_q, expected_d;
    logic          pass_q, pass_d;
    logic          chk_q, chk_d;

    function automatic logic [W-1:0] alu_step(input logic [W-1:0] acc,
                                              input logic [1:0]   op,
                                              input logic [W-1:0] b);
        case (op)
            2'd0:    alu_step = acc + b;
            2'd1:    alu_step = acc - b;
            2'd2:    alu_step = acc | b;
            default: alu_step = acc ^ b;
        endcase
    endfunction

    assign cur        = mem_q[index_q];
    assign load_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        last_d     = last_q;
        expected_d = expected_q;
        pass_d     = pass_q;
        mis_d      = mis_q;
        chk_d      = 1'b0;
        mem_we     = 1'b0;

        // chk_q marks the cycle after an issue, when the ALU result reflects that entry.
        if (chk_q && (seq_io.result != expected_q) && pass_q) begin
            pass_d = 1'b0;
            mis_d  = last_q;
        end

        case (state_q)
            S_IDLE: begin
                if (seq_io.start) begin
                    pass_d = 1'b1;
                    mis_d  = '0;
                    if (count_q != '0) begin
                        expected_d = seq_io.result;
                        index_d    = '0;
                        state_d    = S_RUN;
                    end else begin
                        state_d    = S_DONE;
                    end
                end else if (seq_io.clear) begin
                    count_d = '0;
                end else if (seq_io.load_valid && load_ready) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            S_RUN: begin
                expected_d = alu_step(expected_q, cur.op, cur.operand);
                last_d     = index_q;
                index_d    = index_q + AW'(1);
                chk_d      = 1'b1;
                if (CW'(index_q) == count_q - CW'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            index_q    <= '0;
            last_q     <= '0;
            mis_q      <= '0;
            expected_q <= '0;
            pass_q     <= 1'b0;
            chk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            last_q     <= last_d;
            mis_q      <= mis_d;
            expected_q <= expected_d;
            pass_q     <= pass_d;
            chk_q      <= chk_d;
        end
    end

    // NOTE: the program store has no reset so it maps onto plain RAM; only entries below count_q are ever read.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[count_q[AW-1:0]] <= {seq_io.load_operation, seq_io.load_operand};
        end
    end

    assign seq_io.load_ready     = load_ready;
    assign seq_io.count          = count_q;
    assign seq_io.busy           = (state_q == S_RUN) || (state_q == S_CHECK);
    assign seq_io.done           = (state_q == S_DONE);
    assign seq_io.pass           = pass_q;
    assign seq_io.mismatch_index = mis_q;
    assign seq_io.expected       = expected_q;
    // Outside RUN the ALU sees add 0 and simply holds its accumulator.
    assign seq_io.operation      = (state_q == S_RUN) ? cur.op      : 2'd0;
    assign seq_io.operand        = (state_q == S_RUN) ? cur.operand : '0;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Drives alu_op_sequencer with directed and random programs against a behavioural
// accumulator ALU and a reference model of the expected run outcome.
module tb_alu_op_sequencer;
    localparam int DEPTH = 8;
    localparam int W     = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_op_sequencer_if #(.DEPTH(DEPTH), .W(W)) bus ();

    alu_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .seq_io (bus)
    );

    int checks = 0;
    int errors = 0;

    int prog_op[$];
    int prog_opnd[$];

    logic [W-1:0] alu_acc;
    logic         force_en;
    logic [W-1:0] force_val;

    function automatic int alu_ref(input int a, input int op, input int b);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b + (1 << W);
            2:       r = a | b;
            default: r = a ^ b;
        endcase
        return r % (1 << W);
    endfunction

    // Behavioural accumulator ALU; the bench can override the visible result.
    always @(posedge clock) begin
        if (reset) alu_acc <= '0;
        else       alu_acc <= W'(alu_ref(int'(alu_acc), int'(bus.operation), int'(bus.operand)));
    end
    assign bus.result = force_en ? force_val : alu_acc;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.load_valid     = 1'b0;
        bus.load_operation = 2'd0;
        bus.load_operand   = '0;
        bus.clear          = 1'b0;
        bus.start          = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        prog_op.delete();
        prog_opnd.delete();
    endtask

    task automatic do_load(input int op, input int opnd);
        bit acc;
        acc = (prog_op.size() < DEPTH);
        bus.load_valid     = 1'b1;
        bus.load_operation = 2'(op);
        bus.load_operand   = W'(opnd);
        check("load_ready", int'(bus.load_ready), int'(acc));
        @(negedge clock);
        bus.load_valid = 1'b0;
        if (acc) begin
            prog_op.push_back(op);
            prog_opnd.push_back(opnd);
        end
        check("count_after_load", int'(bus.count), prog_op.size());
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge clock);
        bus.clear = 1'b0;
        prog_op.delete();
        prog_opnd.delete();
        check("count_after_clear", int'(bus.count), 0);
    endtask

    // Runs the loaded program; inj >= 0 overrides the result in the check cycle of entry inj.
    task automatic run_program(input int inj, input int inj_val, input bit abuse);
        int n;
        int trace[$];
        int acc;
        bit pass_e;
        int mis_e;
        n      = prog_op.size();
        acc    = int'(alu_acc);
        pass_e = 1'b1;
        mis_e  = 0;
        trace.push_back(acc);
        for (int k = 0; k < n; k++) begin
            acc = alu_ref(acc, prog_op[k], prog_opnd[k]);
            trace.push_back(acc);
        end
        if (inj >= 0 && inj_val != trace[inj + 1]) begin
            pass_e = 1'b0;
            mis_e  = inj;
        end

        bus.start = 1'b1;
        @(negedge clock);
        idle_inputs();
        for (int c = 0; c <= n; c++) begin
            if (abuse && c < n) begin
                bus.start          = 1'($urandom);
                bus.load_valid     = 1'($urandom);
                bus.clear          = 1'($urandom);
                bus.load_operation = 2'($urandom);
                bus.load_operand   = W'($urandom);
            end else begin
                idle_inputs();
            end
            if (inj >= 0 && c == inj + 1) begin
                force_en  = 1'b1;
                force_val = W'(inj_val);
            end
            if (c < n) begin
                check("run_operation", int'(bus.operation), prog_op[c]);
                check("run_operand", int'(bus.operand), prog_opnd[c]);
            end else begin
                check("check_operation", int'(bus.operation), 0);
                check("check_operand", int'(bus.operand), 0);
            end
            check("run_expected", int'(bus.expected), trace[c]);
            check("run_busy", int'(bus.busy), 1);
            check("run_done", int'(bus.done), 0);
            check("run_load_ready", int'(bus.load_ready), 0);
            @(negedge clock);
            force_en = 1'b0;
        end
        idle_inputs();
        check("done_pulse", int'(bus.done), 1);
        check("done_busy", int'(bus.busy), 0);
        check("done_pass", int'(bus.pass), int'(pass_e));
        check("done_mismatch_index", int'(bus.mismatch_index), mis_e);
        check("done_expected", int'(bus.expected), trace[n]);
        check("done_count", int'(bus.count), n);
        @(negedge clock);
        check("after_done", int'(bus.done), 0);
        check("after_busy", int'(bus.busy), 0);
        check("after_pass", int'(bus.pass), int'(pass_e));
    endtask

    initial begin
        int saved;
        int n;
        int inj;
        force_en  = 1'b0;
        force_val = '0;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("rst_count", int'(bus.count), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_pass", int'(bus.pass), 0);
        check("rst_mismatch_index", int'(bus.mismatch_index), 0);
        check("rst_expected", int'(bus.expected), 0);
        check("rst_operation", int'(bus.operation), 0);
        check("rst_operand", int'(bus.operand), 0);
        check("rst_load_ready", int'(bus.load_ready), 1);

        // Basic program from a zero accumulator.
        do_load(0, 5); do_load(1, 3); do_load(2, 8); do_load(3, 15);
        run_program(-1, 0, 1'b0);

        // Same program with a corrupted result after entry 1.
        pulse_reset();
        do_load(0, 5); do_load(1, 3); do_load(2, 8); do_load(3, 15);
        run_program(1, 7, 1'b0);

        // Add/sub wrap-around.
        pulse_reset();
        do_load(0, 9); do_load(0, 9); do_load(1, 3);
        run_program(-1, 0, 1'b0);

        // Full program store, then clear beating a simultaneous load.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) do_load(int'($urandom_range(3)), int'($urandom_range(15)));
        do_load(1, 1);
        check("full_load_ready", int'(bus.load_ready), 0);
        bus.clear = 1'b1; bus.load_valid = 1'b1;
        @(negedge clock);
        idle_inputs();
        prog_op.delete(); prog_opnd.delete();
        check("clear_beats_load", int'(bus.count), 0);

        // Empty-program start finishes on the next cycle without touching the ALU.
        saved = int'(alu_acc);
        bus.start = 1'b1;
        @(negedge clock);
        idle_inputs();
        check("empty_done", int'(bus.done), 1);
        check("empty_busy", int'(bus.busy), 0);
        check("empty_pass", int'(bus.pass), 1);
        check("empty_operation", int'(bus.operation), 0);
        @(negedge clock);
        check("empty_done_low", int'(bus.done), 0);
        check("empty_alu_held", int'(bus.result), saved);

        // Protocol abuse during RUN, then a replay of the untouched program.
        for (int i = 0; i < 5; i++) do_load(int'($urandom_range(3)), int'($urandom_range(15)));
        run_program(-1, 0, 1'b1);
        run_program(-1, 0, 1'b0);

        // Reset in the middle of a run.
        bus.start = 1'b1;
        @(negedge clock);
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        prog_op.delete(); prog_opnd.delete();
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_count", int'(bus.count), 0);
        check("midrst_operation", int'(bus.operation), 0);
        check("midrst_operand", int'(bus.operand), 0);
        check("midrst_expected", int'(bus.expected), 0);
        check("midrst_load_ready", int'(bus.load_ready), 1);

        // Non-zero starting accumulator.
        do_load(0, 12);
        run_program(-1, 0, 1'b0);
        do_clear();
        do_load(3, 12);
        run_program(-1, 0, 1'b0);
        check("xor_final_expected", int'(bus.expected), 0);

        // Random programs, random faults, random abuse.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(3) == 0) pulse_reset();
            else                        do_clear();
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) do_load(int'($urandom_range(3)), int'($urandom_range(15)));
            inj = ($urandom_range(2) == 0) ? int'($urandom_range(n - 1)) : -1;
            run_program(inj, int'($urandom_range(15)), 1'($urandom));
            if ($urandom_range(1) == 0) run_program(-1, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-issuing counterpart to the team's 4-bit accumulator ALU (ops: 0=add, 1=sub, 2=or, 3=xor; result registered, updates every clock).
- Loads a short program of (operation, operand) pairs and issues one pair per cycle on start.
- Keeps a shadow model of the accumulator and checks the ALU's `result` every cycle.
- Reports pass/fail and the first failing entry.
- Sits directly in front of the ALU as its driver and self-checker in the demo top.

Parameters:
- DEPTH, 8, number of program entries (power of two, ≥2)
- W, 4, operand/result width; must match the ALU

Ports:
- clock, input, 1, single system clock; all logic on rising edge
- reset, input, 1, synchronous, active-high reset
- load_valid, input, 1, program entry offered
- load_ready, output, 1, entry can be accepted
- load_operation, input, 2, opcode for entry
- load_operand, input, W, operand for entry
- clear, input, 1, empty program (IDLE only)
- count, output, $clog2(DEPTH+1), entries loaded
- start, input, 1, begin run (IDLE only)
- busy, output, 1, run in progress
- done, output, 1, one-cycle end-of-run pulse
- pass, output, 1, run result; valid from done onward
- mismatch_index, output, $clog2(DEPTH), first failing entry
- operation, output, 2, to ALU operation
- operand, output, W, to ALU operand
- result, input, W, from ALU result
- expected, output, W, shadow accumulator value

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clock`, `reset`).
- States: IDLE, RUN, CHECK, DONE.
- Reset (synchronous, wins over everything, including mid-run abort): state=IDLE, count=0, index=0, operation=0, operand=0, busy=0, done=0, pass=0, mismatch_index=0, expected=0. Program memory is not cleared.
- Idle drive: outside RUN, operation=0 and operand=0 (add 0), so the ALU holds its value.

IDLE:
- load_ready = (count < DEPTH).
- On load_valid & load_ready: write the entry at address count; count++.
- clear: count <= 0. If clear and a load occur in the same cycle, clear wins and the load is dropped.
- start with count>0: expected <= result (capture the live ALU value), index <= 0, pass <= 1, mismatch_index <= 0, go to RUN.
  - start takes priority over load/clear in the same cycle; the load is not accepted.
- start with count==0: go to DONE with pass=1.

RUN:
- busy=1, load_ready=0; start, clear and load_valid are ignored.
- Each cycle drive operation/operand = mem[index].
- At the edge: expected <= f(expected, op, operand) mod 2^W (add/sub wrap, e.g. 0−1=15), last_issued <= index, index++.
- When index==count−1, go to CHECK.

Checking (the cycle after every issue, in RUN and in CHECK):
- Compare result against expected.
- On the first mismatch: pass <= 0, mismatch_index <= last_issued.
- pass is sticky low until the next start.

CHECK:
- Drives add 0 and performs the final compare, then goes to DONE.

DONE:
- done=1 for exactly one cycle, busy=0, then IDLE.
- count and the program are retained, so start replays the same program.

Timing:
- For N loaded entries, done is high in the cycle after the (N+1)th edge following the edge that sampled start.
- busy is high for N+1 cycles.
- pass, mismatch_index and expected hold until the next start or reset.

Test Plan:
1. Reset ALU and sequencer; load {add 5, sub 3, or 8, xor 15}; start.
   -> operation/operand sequence 0/5, 1/3, 2/8, 3/15 on consecutive cycles; expected 5, 2, 10, 5; done 5 cycles after the start edge; pass=1; count=4.
2. Wrap-around: load {add 9, add 9, sub 3}, ALU at 0.
   -> expected 9, 2, 15; pass=1.
3. Fault injection: bench forces result to 7 in the check cycle of entry 1 of scenario 1.
   -> pass=0, mismatch_index=1; entries 2 and 3 still issued; done on time.
4. Full/priority:
   - Load 8 entries: load_ready drops after the 8th; a 9th load_valid is not accepted; count=8.
   - Then assert clear and load_valid together -> count=0.
   - start with count=0 -> done next cycle, pass=1, no ALU activity.
5. Protocol abuse: start and load_valid during RUN are ignored and the program is unchanged; reset asserted mid-RUN -> next cycle IDLE, busy=0, count=0, operation=0, operand=0.
6. Non-zero initial ALU value: preload the ALU to 12 via one run; second start with {xor 12}.
   -> expected captured as 12, final expected 0, pass=1.
